// File: rtl/i2c_slave_reg_write.sv
// i2c_slave_reg_write: I2C write-only slave that turns received data bytes into register-write strobes
module i2c_slave_reg_write #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h68,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_50,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, WAIT_STOP
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_d, r_sda_d;
    logic [2:0]             r_cnt, w_cnt_nxt;
    logic [7:0]             r_shift, w_shift_nxt;
    logic                   r_sda_oe, w_sda_oe_nxt;
    logic                   r_wr_en, w_wr_en_nxt;
    logic [7:0]             r_wr_addr, w_wr_addr_nxt;
    logic [7:0]             r_wr_data, w_wr_data_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]             w_byte;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & ~r_sda_d & w_sda;
    assign w_byte     = {r_shift[6:0], w_sda};

    assign sda_oe  = r_sda_oe;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;

    // Synchronise the bus lines; reset to the idle-high level so release of reset makes no false edges
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    // State and datapath registers; async clear releases SDA immediately on reset
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            r_shift   <= 8'd0;
            r_sda_oe  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'd0;
            r_wr_data <= 8'd0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_sda_oe  <= w_sda_oe_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    // Next state: bus conditions first, then bit shifting in byte states and ACK sequencing in ACK states
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_sda_oe_nxt  = r_sda_oe;
        w_wr_en_nxt   = 1'b0;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_busy_nxt    = r_busy;
        if (w_stop) begin
            w_state_nxt  = IDLE;
            w_cnt_nxt    = 3'd0;
            w_shift_nxt  = 8'd0;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt  = ADDR;
            w_cnt_nxt    = 3'd0;
            w_shift_nxt  = 8'd0;
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                ADDR, REG, DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (r_state == ADDR) begin
                                w_busy_nxt  = (w_byte[7:1] == SLAVE_ADDR) && !w_byte[0];
                                w_state_nxt = w_busy_nxt ? ADDR_ACK : WAIT_STOP;
                            end else if (r_state == REG) begin
                                w_wr_addr_nxt = w_byte;
                                w_state_nxt   = REG_ACK;
                            end else begin
                                w_wr_data_nxt = w_byte;
                                w_state_nxt   = DATA_ACK;
                            end
                        end
                    end
                end
                ADDR_ACK, REG_ACK, DATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_sda_oe_nxt = 1'b1;
                            w_wr_en_nxt  = (r_state == DATA_ACK);
                        end else begin
                            w_sda_oe_nxt  = 1'b0;
                            w_cnt_nxt     = 3'd0;
                            w_state_nxt   = (r_state == ADDR_ACK) ? REG : DATA;
                            w_wr_addr_nxt = (r_state == DATA_ACK) ? r_wr_addr + 8'd1 : r_wr_addr;
                        end
                    end
                end
                IDLE, WAIT_STOP: w_sda_oe_nxt = 1'b0;
                default: w_state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave_reg_write.sv
// tb_i2c_slave_reg_write: directed and random I2C write transactions checked against a transaction-level model
module tb_i2c_slave_reg_write;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe, wr_en, busy;
    logic [7:0] wr_addr, wr_data;

    int passed = 0;
    int total = 0;
    int dbl = 0;
    bit prev_wr = 0;
    bit oe_seen = 0;
    bit busy_seen = 0;
    logic [15:0] obs_q[$];
    logic [7:0]  tx[$];

    assign sda_in = sda_m & ~sda_oe;

    i2c_slave_reg_write dut (
        .clk_50 (clk),
        .reset  (reset),
        .scl    (scl_m),
        .sda_in (sda_in),
        .sda_oe (sda_oe),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy   (busy)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) obs_q.push_back({wr_addr, wr_data});
            if (wr_en && prev_wr) dbl++;
            prev_wr = wr_en;
            if (sda_oe) oe_seen = 1;
            if (busy) busy_seen = 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b0; qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; qwait();
        scl_m = 1'b1; qwait();
        sda_m = 1'b1; qwait(); qwait();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b; qwait();
        scl_m = 1'b1; qwait(); qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        ack = sda_oe;
        qwait();
        scl_m = 1'b0; qwait();
    endtask

    task automatic run(input bit do_stop, input string name);
        logic        acks[$];
        logic [15:0] exp_w[$];
        logic [7:0]  ra;
        logic        a;
        bit          match;
        obs_q.delete();
        oe_seen = 0;
        busy_seen = 0;
        i2c_start();
        foreach (tx[i]) begin
            send_byte(tx[i], a);
            acks.push_back(a);
        end
        if (do_stop) i2c_stop();
        repeat (6) @(negedge clk);
        match = (tx[0][7:1] == 7'h68) && !tx[0][0];
        if (match)
            for (int i = 2; i < tx.size(); i++) begin
                ra = tx[1] + 8'(i - 2);
                exp_w.push_back({ra, tx[i]});
            end
        foreach (acks[i]) chk($sformatf("%s ack%0d", name, i), 32'(acks[i]), 32'(match));
        chk({name, " nwrites"}, 32'(obs_q.size()), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && i < obs_q.size(); i++)
            chk($sformatf("%s write%0d", name, i), 32'(obs_q[i]), 32'(exp_w[i]));
        chk({name, " oe_seen"}, 32'(oe_seen), 32'(match));
        chk({name, " busy_seen"}, 32'(busy_seen), 32'(match));
        if (do_stop) begin
            chk({name, " busy after stop"}, 32'(busy), 32'd0);
            chk({name, " oe after stop"}, 32'(sda_oe), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] d;
        repeat (5) @(negedge clk);
        chk("reset sda_oe", 32'(sda_oe), 32'd0);
        chk("reset wr_en", 32'(wr_en), 32'd0);
        chk("reset wr_addr", 32'(wr_addr), 32'd0);
        chk("reset wr_data", 32'(wr_data), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        tx = '{8'hD0, 8'h38, 8'hF0};             run(1, "basic");
        tx = '{8'hA0, 8'h12, 8'h34};             run(1, "wrong addr");
        tx = '{8'hD1, 8'h12};                    run(1, "read");
        tx = '{8'hD0, 8'h01, 8'h5A};             run(1, "after read");
        tx = '{8'hD0, 8'hFF, 8'hAA, 8'h55};      run(1, "wrap");

        tx = '{8'hD0, 8'h40};                    run(0, "partial head");
        obs_q.delete();
        for (int i = 0; i < 4; i++) send_bit(1'(i));
        i2c_stop();
        repeat (6) @(negedge clk);
        chk("partial nwrites", 32'(obs_q.size()), 32'd0);
        chk("partial oe", 32'(sda_oe), 32'd0);
        chk("partial busy", 32'(busy), 32'd0);

        tx = '{8'hD0, 8'h22};                    run(0, "rs head");
        tx = '{8'hD0, 8'h10, 8'h77};             run(1, "rs body");

        for (int n = 0; n < 16; n++) begin
            tx.delete();
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hD0;
            tx.push_back(d);
            for (int k = $urandom_range(0, 4); k > 0; k--) tx.push_back(8'($urandom));
            run(1, $sformatf("rand%0d", n));
        end

        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 6 || i == 7 || i == 4);
        sda_m = 1'b1; qwait();
        scl_m = 1'b1; qwait();
        chk("pre-reset oe", 32'(sda_oe), 32'd1);
        #3 reset = 1'b1;
        #1;
        chk("async reset oe", 32'(sda_oe), 32'd0);
        chk("async reset busy", 32'(busy), 32'd0);
        chk("async reset wr_en", 32'(wr_en), 32'd0);
        chk("async reset addr", 32'(wr_addr), 32'd0);
        chk("async reset data", 32'(wr_data), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        scl_m = 1'b0; qwait();
        i2c_stop();
        tx = '{8'hD0, 8'h05, 8'hC3};             run(1, "post reset");

        chk("wr_en back-to-back", 32'(dbl), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
